// File: rtl/clk_pkg.sv
// rtl/clk_pkg.sv - shared state encoding and width helper for the PLL lock manager
// Contents:
//   state_t : FSM state encoding (WAIT_LOCK=0, FILTER=1, RELEASE=2, RUN=3)
//   clog2   : ceiling log2, used to size counters from parameters
package clk_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_FILTER    = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/clk_en_div.sv
// rtl/clk_en_div.sv - single-channel programmable clock-enable divider
// Ports:
//   clock_in : system clock
//   reset_n  : asynchronous active-low reset
//   run      : channel released; the divide counter is held at 0 while low
//   div      : divide value; pulse period is div+1 cycles
//   en       : clock-enable pulse, high on cycles where the counter is 0
module clk_en_div #(
    parameter int DIV_W = 8
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             en
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;

    // div is captured only at the start of a period so a mid-period change
    // never shortens or stretches the period already in progress.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            div_q <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (cnt == '0) begin
            div_q <= div;
            cnt   <= (div == '0) ? '0 : DIV_W'(1);
        end else if (cnt == div_q) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    // Both terms are flops; gating with run makes the first pulse coincide
    // with the first released cycle and kills the enable the cycle reset
    // is re-asserted.
    assign en = run & (cnt == '0);

endmodule

// File: rtl/pll_lock_manager.sv
// rtl/pll_lock_manager.sv - PLL lock filter, staged reset release and clock-enable generation
// Ports:
//   clock_in   : system clock (PLL output domain)
//   reset_n    : asynchronous active-low reset
//   locked_in  : raw PLL lock flag, asynchronous to clock_in
//   sw_reset   : level request to re-sequence, sampled every cycle
//   ch_div     : per-channel divide values, channel k at [k*DIV_W +: DIV_W]
//   rst_out_n  : per-channel active-low resets
//   clk_en     : per-channel clock-enable pulses
//   ready      : all channels released
//   loss_count : saturating count of lock losses
//   state      : FSM state (0 WAIT_LOCK, 1 FILTER, 2 RELEASE, 3 RUN)
module pll_lock_manager
    import clk_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int LOCK_FILTER = 1024,
    parameter int STAGE_GAP   = 256,
    parameter int DIV_W       = 8,
    parameter int CNT_W       = 8
) (
    input  logic                    clock_in,
    input  logic                    reset_n,
    input  logic                    locked_in,
    input  logic                    sw_reset,
    input  logic [NUM_CH*DIV_W-1:0] ch_div,
    output logic [NUM_CH-1:0]       rst_out_n,
    output logic [NUM_CH-1:0]       clk_en,
    output logic                    ready,
    output logic [CNT_W-1:0]        loss_count,
    output logic [2:0]              state
);

    localparam int FILT_W = clog2(LOCK_FILTER + 1);
    localparam int GAP_W  = clog2(STAGE_GAP + 1);
    localparam int IDX_W  = (NUM_CH > 1) ? clog2(NUM_CH) : 1;

    logic              sync_meta;
    logic              lock_s;
    state_t            st;
    logic [FILT_W-1:0] filt_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [IDX_W-1:0]  ch_idx;
    logic              in_seq;
    logic              lock_lost;

    assign in_seq    = (st == ST_RELEASE) || (st == ST_RUN);
    assign lock_lost = in_seq && !lock_s;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta  <= 1'b0;
            lock_s     <= 1'b0;
            st         <= ST_WAIT_LOCK;
            filt_cnt   <= '0;
            gap_cnt    <= '0;
            ch_idx     <= '0;
            rst_out_n  <= '0;
            ready      <= 1'b0;
            loss_count <= '0;
        end else begin
            sync_meta <= locked_in;
            lock_s    <= sync_meta;

            // Lock loss takes priority over sw_reset so a coincident pair
            // is still counted.
            if (lock_lost || sw_reset) begin
                st        <= ST_WAIT_LOCK;
                filt_cnt  <= '0;
                gap_cnt   <= '0;
                ch_idx    <= '0;
                rst_out_n <= '0;
                ready     <= 1'b0;
                if (lock_lost && !(&loss_count)) begin
                    loss_count <= loss_count + CNT_W'(1);
                end
            end else begin
                case (st)
                    ST_WAIT_LOCK: begin
                        filt_cnt <= '0;
                        // The first locked cycle already counts toward the filter.
                        if (lock_s) begin
                            st       <= ST_FILTER;
                            filt_cnt <= FILT_W'(1);
                        end
                    end
                    ST_FILTER: begin
                        if (!lock_s) begin
                            st       <= ST_WAIT_LOCK;
                            filt_cnt <= '0;
                        end else if (filt_cnt == FILT_W'(LOCK_FILTER - 1)) begin
                            st       <= ST_RELEASE;
                            filt_cnt <= '0;
                            ch_idx   <= '0;
                            gap_cnt  <= '0;
                        end else begin
                            filt_cnt <= filt_cnt + FILT_W'(1);
                        end
                    end
                    ST_RELEASE: begin
                        if (&rst_out_n) begin
                            st    <= ST_RUN;
                            ready <= 1'b1;
                        end else if (gap_cnt == '0) begin
                            rst_out_n[ch_idx] <= 1'b1;
                            gap_cnt           <= GAP_W'(STAGE_GAP - 1);
                            if (ch_idx != IDX_W'(NUM_CH - 1)) begin
                                ch_idx <= ch_idx + IDX_W'(1);
                            end
                        end else begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end
                    end
                    ST_RUN: begin
                        ready <= 1'b1;
                    end
                    default: begin
                        st <= ST_WAIT_LOCK;
                    end
                endcase
            end
        end
    end

    assign state = st;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_en_div #(
            .DIV_W (DIV_W)
        ) u_div (
            .clock_in (clock_in),
            .reset_n  (reset_n),
            .run      (rst_out_n[k]),
            .div      (ch_div[k*DIV_W +: DIV_W]),
            .en       (clk_en[k])
        );
    end

endmodule

// File: tb/tb_pll_lock_manager.sv
// tb/tb_pll_lock_manager.sv - self-checking bench for pll_lock_manager
module tb_pll_lock_manager;

    localparam int NUM_CH      = 3;
    localparam int LOCK_FILTER = 8;
    localparam int STAGE_GAP   = 4;
    localparam int DIV_W       = 4;
    localparam int CNT_W       = 2;
    localparam int LOSS_MAX    = (1 << CNT_W) - 1;

    logic                    clock_in;
    logic                    reset_n;
    logic                    locked_in;
    logic                    sw_reset;
    logic [NUM_CH*DIV_W-1:0] ch_div;
    logic [NUM_CH-1:0]       rst_out_n;
    logic [NUM_CH-1:0]       clk_en;
    logic                    ready;
    logic [CNT_W-1:0]        loss_count;
    logic [2:0]              state;

    pll_lock_manager #(
        .NUM_CH      (NUM_CH),
        .LOCK_FILTER (LOCK_FILTER),
        .STAGE_GAP   (STAGE_GAP),
        .DIV_W       (DIV_W),
        .CNT_W       (CNT_W)
    ) dut (
        .clock_in   (clock_in),
        .reset_n    (reset_n),
        .locked_in  (locked_in),
        .sw_reset   (sw_reset),
        .ch_div     (ch_div),
        .rst_out_n  (rst_out_n),
        .clk_en     (clk_en),
        .ready      (ready),
        .loss_count (loss_count),
        .state      (state)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks the edge number at which channel 0 releases and
    // derives every channel's reset, ready and pulse timing from that.
    int          n;
    int          lk;
    bit          seq;
    int          rel;
    int          loss_m;
    int          pa [NUM_CH];
    bit          hist1, hist2;
    logic [NUM_CH-1:0] e_rst, e_en;
    logic        e_ready;
    logic [2:0]  e_state;

    task automatic model_clear();
        n = 0; lk = 0; seq = 1'b0; rel = 0; loss_m = 0;
        hist1 = 1'b0; hist2 = 1'b0;
        for (int k = 0; k < NUM_CH; k++) pa[k] = -1;
        e_rst = '0; e_en = '0; e_ready = 1'b0; e_state = 3'd0;
    endtask

    task automatic model_step();
        bit ls;
        bit r;
        logic [DIV_W-1:0] d;
        n++;
        ls    = hist2;
        hist2 = hist1;
        hist1 = locked_in;
        if (seq && !ls) begin
            if (loss_m < LOSS_MAX) loss_m++;
            seq = 1'b0; lk = 0;
        end else if (sw_reset) begin
            seq = 1'b0; lk = 0;
        end else if (!seq) begin
            if (ls) begin
                lk++;
                if (lk == LOCK_FILTER) begin
                    seq = 1'b1; rel = n + 1; lk = 0;
                end
            end else begin
                lk = 0;
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            r = seq && (n >= rel + STAGE_GAP * k);
            d = ch_div[k*DIV_W +: DIV_W];
            if (!r) pa[k] = -1;
            else if (pa[k] < 0) pa[k] = n;
            else if (pa[k] == n - 1) pa[k] = n + int'(d);
            e_rst[k] = r;
            e_en[k]  = r && (pa[k] == n);
        end
        e_ready = seq && (n >= rel + STAGE_GAP * (NUM_CH - 1) + 1);
        e_state = seq ? (e_ready ? 3'd3 : 3'd2) : ((lk > 0) ? 3'd1 : 3'd0);
    endtask

    always @(posedge clock_in) begin
        if (reset_n) model_step();
    end

    task automatic tick();
        @(negedge clock_in);
        check_eq("rst_out_n", 32'(rst_out_n), 32'(e_rst));
        check_eq("clk_en", 32'(clk_en), 32'(e_en));
        check_eq("ready", 32'(ready), 32'(e_ready));
        check_eq("loss_count", 32'(loss_count), 32'(loss_m));
        check_eq("state", 32'(state), 32'(e_state));
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        model_clear();
        #1;
        check_eq("async_rst_out_n", 32'(rst_out_n), 32'h0);
        check_eq("async_clk_en", 32'(clk_en), 32'h0);
        check_eq("async_ready", 32'(ready), 32'h0);
        check_eq("async_loss", 32'(loss_count), 32'h0);
        check_eq("async_state", 32'(state), 32'h0);
        locked_in = 1'b0;
        sw_reset  = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    // Lock sampled high from edge 10: releases at 20/24/28, ready at 29.
    task automatic seq_from_reset();
        locked_in = 1'b0;
        sw_reset  = 1'b0;
        while (n < 9) tick();
        locked_in = 1'b1;
        while (n < 30) begin
            tick();
            if (n == 19) check_eq("s1_rst19", 32'(rst_out_n), 32'h0);
            if (n == 20) begin
                check_eq("s1_rst20", 32'(rst_out_n), 32'h1);
                check_eq("s1_en20", 32'(clk_en), 32'h1);
            end
            if (n == 23) check_eq("s1_rst23", 32'(rst_out_n), 32'h1);
            if (n == 24) begin
                check_eq("s1_rst24", 32'(rst_out_n), 32'h3);
                check_eq("s1_en24", 32'(clk_en), 32'h3);
            end
            if (n == 28) begin
                check_eq("s1_rst28", 32'(rst_out_n), 32'h7);
                check_eq("s1_en28", 32'(clk_en), 32'h7);
                check_eq("s1_ready28", 32'(ready), 32'h0);
            end
            if (n == 29) begin
                check_eq("s1_ready29", 32'(ready), 32'h1);
                check_eq("s1_state29", 32'(state), 32'h3);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s_edge;
        int c0, c1, c2;
        int r;
        int kk;
        reset_n   = 1'b0;
        locked_in = 1'b0;
        sw_reset  = 1'b0;
        ch_div    = {4'd2, 4'd3, 4'd0};
        model_clear();
        repeat (2) @(posedge clock_in);
        repeat (2) tick();
        check_eq("reset_state", 32'(state), 32'h0);
        check_eq("reset_rst", 32'(rst_out_n), 32'h0);
        reset_n = 1'b1;

        // Scenario 1 and 4 alignment
        seq_from_reset();

        // Scenario 4: pulse counts over 12 cycles in RUN
        c0 = 0; c1 = 0; c2 = 0;
        repeat (12) begin
            tick();
            c0 += int'(clk_en[0]); c1 += int'(clk_en[1]); c2 += int'(clk_en[2]);
        end
        check_eq("s4_cnt_ch0", 32'(c0), 32'd12);
        check_eq("s4_cnt_ch1", 32'(c1), 32'd3);
        check_eq("s4_cnt_ch2", 32'(c2), 32'd4);

        // Scenario 3: lock loss from RUN, then saturate
        locked_in = 1'b0;
        repeat (3) tick();
        check_eq("s3_loss1", 32'(loss_count), 32'd1);
        check_eq("s3_rst_off", 32'(rst_out_n), 32'h0);
        check_eq("s3_ready_off", 32'(ready), 32'h0);
        for (int i = 0; i < 4; i++) begin
            locked_in = 1'b1;
            repeat (20) tick();
            locked_in = 1'b0;
            repeat (3) tick();
            check_eq("s3_loss_sat", 32'(loss_count), 32'((i + 2 > LOSS_MAX) ? LOSS_MAX : i + 2));
        end

        // Scenario 5: sw_reset pulse in RUN
        locked_in = 1'b1;
        repeat (25) tick();
        check_eq("s5_in_run", 32'(state), 32'h3);
        sw_reset = 1'b1;
        tick();
        sw_reset = 1'b0;
        s_edge = n;
        check_eq("s5_rst_off", 32'(rst_out_n), 32'h0);
        check_eq("s5_loss_kept", 32'(loss_count), 32'(LOSS_MAX));
        while (n < s_edge + 9) begin
            tick();
            if (n == s_edge + 8) check_eq("s5_rst_pre", 32'(rst_out_n), 32'h0);
            if (n == s_edge + 9) check_eq("s5_rst_rel", 32'(rst_out_n), 32'h1);
        end

        // Scenario 2: lock glitch during filtering
        do_reset();
        locked_in = 1'b1;
        while (n < 5) tick();
        locked_in = 1'b0;
        tick();
        locked_in = 1'b1;
        while (n < 17) begin
            tick();
            if (n == 16) check_eq("s2_rst16", 32'(rst_out_n), 32'h0);
            if (n == 17) check_eq("s2_rst17", 32'(rst_out_n), 32'h1);
        end
        check_eq("s2_loss", 32'(loss_count), 32'h0);

        // Scenario 6: reset_n mid-RELEASE with only channel 0 released
        do_reset();
        locked_in = 1'b1;
        while (n < 12) tick();
        check_eq("s6_partial", 32'(rst_out_n), 32'h1);
        check_eq("s6_release", 32'(state), 32'h2);
        do_reset();
        seq_from_reset();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 999));
            sw_reset = (r < 8);
            if (r >= 8 && r < 40) locked_in = ~locked_in;
            if ($urandom_range(0, 49) == 0) begin
                kk = int'($urandom_range(0, NUM_CH - 1));
                ch_div[kk*DIV_W +: DIV_W] = DIV_W'($urandom);
            end
            if ($urandom_range(0, 1499) == 0) begin
                do_reset();
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
